// File: rtl/memoria_dados_param_if.sv
// Bus interface of the nRISC parametrised data memory.
// The master drives address, write data and the three request strobes.
// The slave, which is the memory, returns the read data and the status strobes.
interface memoria_dados_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] Endereco;
    logic [DATA_WIDTH-1:0] DadoEscr;
    logic                  EscMem;
    logic                  LerMem;
    logic                  Limpar;
    logic [DATA_WIDTH-1:0] DadoLido;
    logic                  DadoValido;
    logic                  Ocupado;
    logic                  ErroEnd;

    modport master (
        output Endereco, DadoEscr, EscMem, LerMem, Limpar,
        input  DadoLido, DadoValido, Ocupado, ErroEnd
    );

    modport slave (
        input  Endereco, DadoEscr, EscMem, LerMem, Limpar,
        output DadoLido, DadoValido, Ocupado, ErroEnd
    );
endinterface

// File: rtl/memoria_dados_param.sv
// Parametrised data memory for the nRISC datapath.
// - Registered read with a one-cycle DadoValido strobe.
// - ErroEnd strobe when an accepted access has an address at or beyond DEPTH.
// - Sequential clear sweep, one word per cycle, while Ocupado is high.
//   The sweep runs after reset and whenever Limpar is requested.
// Optional build macro: MEM_DADOS_BYPASS_EN.
// - Defined: write-first. A same-cycle read of the written word returns DadoEscr.
// - Undefined: read-first. The read returns the previous contents.
module memoria_dados_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 128
) (
    input logic                 clock,
    input logic                 reset,   // synchronous, active-low
    memoria_dados_param_if.slave bus
);

    localparam int                  CNT_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        LIMPA,   // clear sweep in progress
        PRONTO   // normal access
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] dado_lido_q;
    logic                  dado_valido_q;
    logic                  erro_end_q;
    logic                  ocupado_q;

    // NOTE: the array has no reset branch. Its contents become defined through the
    // clear sweep, so it can map onto plain RAM with no reset network.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic [CNT_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  wr_en;
    logic                  clr_en;

    // Address decode, array write enables and read-data selection.
    always_comb begin
        // NOTE: every signal written here gets a default first.
        // Without that, a path that skips an assignment would infer a latch.
        in_range  = ({1'b0, bus.Endereco} < DEPTH_EXT);
        idx       = bus.Endereco[CNT_W-1:0];
        clr_en    = reset && (state_q == LIMPA);
        wr_en     = reset && (state_q == PRONTO) && !bus.Limpar && bus.EscMem && in_range;
        rd_data_d = '0;
        if (in_range) begin
`ifdef MEM_DADOS_BYPASS_EN
            rd_data_d = bus.EscMem ? bus.DadoEscr : mem[idx];
`else
            rd_data_d = mem[idx];
`endif
        end
    end

    // Array write port. The sweep and normal writes are mutually exclusive by state.
    always_ff @(posedge clock) begin
        if (clr_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            mem[idx] <= bus.DadoEscr;
        end
    end

    // Control FSM with registered read data and status strobes.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        // Every register then samples the pre-edge values and no simulation race can occur.
        if (!reset) begin
            state_q       <= LIMPA;
            cnt_q         <= '0;
            dado_lido_q   <= '0;
            dado_valido_q <= 1'b0;
            erro_end_q    <= 1'b0;
            ocupado_q     <= 1'b1;
        end else begin
            case (state_q)
                LIMPA: begin
                    dado_valido_q <= 1'b0;
                    erro_end_q    <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_q   <= PRONTO;
                        ocupado_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRONTO: begin
                    if (bus.Limpar) begin
                        state_q       <= LIMPA;
                        cnt_q         <= '0;
                        ocupado_q     <= 1'b1;
                        dado_valido_q <= 1'b0;
                        erro_end_q    <= 1'b0;
                    end else begin
                        dado_valido_q <= bus.LerMem;
                        erro_end_q    <= (bus.EscMem || bus.LerMem) && !in_range;
                        if (bus.LerMem) begin
                            dado_lido_q <= rd_data_d;
                        end
                    end
                end
                default: begin
                    state_q   <= LIMPA;
                    cnt_q     <= '0;
                    ocupado_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.DadoLido   = dado_lido_q;
    assign bus.DadoValido = dado_valido_q;
    assign bus.ErroEnd    = erro_end_q;
    assign bus.Ocupado    = ocupado_q;

endmodule
